// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU MAR/MDR bus. A level request (read or
//   write) is latched in IDLE. It then waits WAIT_STATES cycles and performs
//   one RAM access. The result is acknowledged with a four-phase mem_done
//   handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   mar_addr   in   [31:0] word address
//   mdr_wdata  in   [31:0] write data
//   read       in   read request (level, held until mem_done)
//   write      in   write request (level, held until mem_done)
//   mem_rdata  out  [31:0] registered read data, held until the next read
//   mem_done   out  registered acknowledge
//   mem_err    out  registered error flag, valid while mem_done=1
//   busy       out  high whenever the FSM is not in IDLE
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mar_addr,
  input  logic [31:0] mdr_wdata,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_BOTH
  } op_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
  localparam int         DEPTH    = 1 << ADDR_W;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [31:0] ram [0:DEPTH-1];

  logic [ADDR_W-1:0] ram_idx;
  logic              in_range;
  logic              ram_we;

  assign ram_idx  = addr_q[ADDR_W-1:0];
  // Any set bit above the RAM depth is an out-of-range access.
  assign in_range = (addr_q[31:ADDR_W] == '0);
  assign ram_we   = (state_q == S_ACCESS) && (op_q == OP_WRITE) && in_range;

  // RAM storage is deliberately not reset. A reset only cancels a pending
  // write, because it moves the FSM out of WAIT before the ACCESS edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      wcnt_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (read ^ write) begin
          addr_d  = mar_addr;
          wdata_d = mdr_wdata;
          op_d    = write ? OP_WRITE : OP_READ;
          wcnt_d  = WAIT_CNT;
          state_d = (WAIT_CNT != 4'd0) ? S_WAIT : S_ACCESS;
        end else if (read && write) begin
          // Conflicting request: skip the wait states and report an error.
          addr_d  = mar_addr;
          op_d    = OP_BOTH;
          wcnt_d  = 4'd0;
          state_d = S_ACCESS;
        end
      end

      S_WAIT: begin
        // The request inputs are ignored here. The latched copy drives the access.
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        done_d  = 1'b1;
        state_d = S_DONE;
        case (op_q)
          OP_READ: begin
            rdata_d = in_range ? ram[ram_idx] : 32'd0;
            err_d   = !in_range;
          end
          OP_WRITE: begin
            err_d = !in_range;
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
      end

      S_DONE: begin
        // Hold the acknowledge until both requests are released. If the
        // master already dropped its request, this gives a one-cycle pulse.
        if (!read && !write) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_rdata = rdata_q;
  assign mem_done  = done_q;
  assign mem_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's MAR/MDR memory bus. The control unit raises `read` or `write` with the address on `mar_addr` and, for writes, data on `mdr_wdata`. This block services the request against an internal word-addressed RAM with a programmable number of wait states, and acknowledges it with a four-phase `mem_done` handshake. `mem_rdata` feeds the MDR input mux.

## Interface
- `ADDR_W`, default 9: word-address width; RAM depth is 2^ADDR_W words.
- `WAIT_STATES`, default 1: extra cycles inserted before the access; legal range 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mar_addr`  in  32  word address from MAR.
- `mdr_wdata`  in  32  write data from MDR.
- `read`  in  1  read request, level; held until `mem_done` is seen.
- `write`  in  1  write request, level; held until `mem_done` is seen.
- `mem_rdata`  out  32  registered read data; holds its value until the next completed read.
- `mem_done`  out  1  registered acknowledge.
- `mem_err`  out  1  registered error flag; valid while `mem_done`=1.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- States are IDLE, WAIT, ACCESS, DONE. A 4-bit wait counter `wcnt` supports them.
- **IDLE**
  - If `read` xor `write` is high, latch the address, write data and op, then load `wcnt`=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - If `read` and `write` are both high, latch an error op and go to ACCESS.
- **WAIT**
  - Decrement `wcnt`; go to ACCESS on the edge where `wcnt`=1.
  - Inputs are ignored here; latched values are used.
- **ACCESS** (one cycle)
  - Write: RAM[addr] <= latched data.
  - Read: `mem_rdata` <= RAM[addr].
  - Then go to DONE, with `mem_done` <= 1.
- **DONE**
  - Hold `mem_done`=1 (and `mem_err` if set).
  - Go to IDLE on the first edge where `read`=`write`=0; `mem_done` and `mem_err` clear on that edge.
- **Address range:** if `mar_addr[31:ADDR_W]` != 0, the access sets `mem_err`=1.
  - The write is dropped.
  - A read returns `mem_rdata`=0.
- **Both requests high:** `mem_err`=1, no RAM access, `mem_rdata` unchanged.
- **Early request drop (abort):** an access already latched always completes.
  - A write still commits.
  - `mem_done` is high for exactly one cycle, then the FSM returns to IDLE.
- **Back-to-back requests:** a new request is accepted only from IDLE. After DONE there must be at least one cycle with both requests low.
- **RAM:** single-port, with no read-during-write case because ops are exclusive.
- **Reset:**
  - Asynchronous reset forces IDLE with `mem_done`=0, `mem_err`=0, `mem_rdata`=0, `busy`=0 and `wcnt`=0.
  - RAM contents are not cleared.
  - Asserting reset before the ACCESS edge cancels a write.

## Timing
- The request is sampled on edge E0 (FSM in IDLE).
- The RAM access occurs on edge E(WAIT_STATES+1).
- `mem_done` and `mem_rdata` are valid after that same edge: latency WAIT_STATES+2 edges counting E0 as the first.
- With WAIT_STATES=0, `mem_done` rises after E1.
- With WAIT_STATES=1, `mem_done` rises after E2.
- `busy` is high from after E0 until after the edge that returns the FSM to IDLE.
- `mem_done` falls one edge after both requests are seen low.
- Minimum request-to-request period: WAIT_STATES+3 cycles.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- **Write then read, WAIT_STATES=1:**
  - Write 0xDEADBEEF to address 0x012, then read address 0x012.
  - `mem_done` rises after the 3rd edge of each request.
  - `mem_rdata`=0xDEADBEEF; `mem_err`=0.
- **Out-of-range address:**
  - Read 0x00000200 (ADDR_W=9): `mem_done`=1, `mem_err`=1, `mem_rdata`=0x00000000.
  - Write 0x55 to 0x00000200, then read 0x000: the prior value at 0x000 is unchanged.
- **Both requests high:**
  - `read`=`write`=1 with address 0x004 holding 0x11: `mem_done`=1, `mem_err`=1.
  - RAM[0x004] still reads 0x11.
- **Abort:**
  - Raise `write` (0xA5A5A5A5 to 0x020), drop it after E0.
  - Write commits; `mem_done` is high for exactly 1 cycle; `busy` then drops.
  - A subsequent read of 0x020 returns 0xA5A5A5A5.
- **Reset:**
  - Assert `reset_n`=0 asynchronously during WAIT of a write of 0x1234 to 0x030, where RAM[0x030]=0x0.
  - Outputs are 0 immediately and the FSM is in IDLE.
  - A later read of 0x030 returns 0x0.
- **Handshake hold, WAIT_STATES=0:**
  - Keep `read` high for 5 cycles after `mem_done` rises.
  - `mem_done` stays 1 and no second access occurs (`busy` stays 1).
  - `mem_done` clears one edge after `read`=0.
